factor_scan_ctrl: RTL and testbench
===================================

# factor_scan_ctrl

Sequential controller for divisibility scanning. It accepts a number over a valid/ready request port and tests every divisor 2..MAX_DIV in turn on one shared serial remainder unit. It returns the resulting factor mask over a valid/ready response port. It sits between the input-switch capture logic and the display/GPIO sequencer, and replaces a parallel bank of divisibility checkers with one time-shared datapath.

## Interface
- WIDTH, 8: bit width of the number under test.
- MAX_DIV, 17: largest divisor tested. The mask width is D = MAX_DIV-1.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request number is valid.
- req_ready  out  1  controller can accept a request.
- req_number  in  WIDTH  number to factor.
- rsp_valid  out  1  result is available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_factors  out  D  bit i = 1 when (i+2) divides the number.
- rsp_number  out  WIDTH  the number the result belongs to.
- abort  in  1  synchronous cancel of the scan or pending result.
- busy  out  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready = !abort.
  - On req_valid && req_ready: latch req_number, clear the mask, set the divisor counter to 2, load the remainder unit, go to RUN.
- RUN:
  - Each divisor occupies WIDTH+1 cycles: one load cycle, then WIDTH restoring shift-subtract iterations, MSB first.
  - At the end of a divisor's slot, mask[d-2] <= (remainder == 0).
  - If d == MAX_DIV, go to DONE. Otherwise d <= d+1 and reload the unit.
- DONE:
  - rsp_valid = 1.
  - rsp_factors and rsp_number stay stable until rsp_valid && rsp_ready, then go to IDLE.
  - req_ready = 0, so there is a one-cycle bubble before the next accept.
- Abort:
  - In RUN or DONE, the FSM goes to IDLE on the next edge. The partial mask is discarded and no response is produced.
  - Abort has priority over the rsp handshake and over the final-divisor completion in the same cycle.
- Arithmetic:
  - The divisor counter is ceil(log2(MAX_DIV+1)) bits wide.
  - The partial remainder is WIDTH+1 bits wide to hold the borrow. The divisor is zero-extended to WIDTH+1 bits.
- Special values:
  - Number 0 gives an all-ones mask.
  - Number 1 gives an all-zeros mask.
  - A divisor larger than the number gives 0 for that bit, except when the number is 0.
- req_number is sampled only at the accept edge. Changes during RUN are ignored.

## Timing
- Reset values:
  - state = IDLE, req_ready = 1.
  - rsp_valid = 0, busy = 0.
  - rsp_factors = 0, rsp_number = 0.
  - Divisor counter = 2, remainder unit cleared.
- Fixed latency: accept edge = edge 0. The last mask bit and rsp_valid are both registered on edge D*(WIDTH+1), which is edge 144 for the defaults.
- rsp_valid is never combinationally dependent on rsp_ready.
- The output is registered; nothing combinational goes from req_* to rsp_*.
- When rst_n is asserted mid-scan, all state clears immediately and no response is emitted after release.
- busy rises on the edge after accept (edge 0) and falls on the edge where the rsp handshake or abort occurs.

## Structure
- Shared package factor_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the localparam for mask width (MAX_DIV-1);
  - the divisor-counter width function.
- Sub-module mod_serial: restoring remainder unit.
  - Ports: clk, rst_n, load, dividend[WIDTH], divisor[WIDTH], rem[WIDTH], done.
  - done pulses in the WIDTH-th iteration cycle after load.
  - The controller instantiates exactly one.
- The controller owns the FSM, the divisor counter, the mask register and the output registers.

## Test plan
- Accept 12, rsp_ready held high -> rsp_factors = 0x0417 and rsp_number = 12, with rsp_valid rising exactly on edge 144 after accept.
- Sequential requests 0, 1, 17, 255 -> 0xFFFF, 0x0000, 0x8000, 0xA00A. req_ready must be low through each scan and DONE.
- Accept 12 with rsp_ready held low for 20 cycles -> rsp_valid and rsp_factors = 0x0417 stay stable, req_ready stays 0, the next request is accepted only in IDLE.
- Accept 12, pulse abort at edge 50 -> IDLE next edge, no rsp_valid ever. A subsequent request for 255 returns 0xA00A.
- Abort asserted on the same edge as the rsp handshake in DONE -> result dropped, FSM in IDLE, no duplicate response.
- rst_n low for 1 cycle at edge 70 of a scan -> all outputs at reset values asynchronously, req_ready = 1 after release, no stale response.

Source files
------------

// File: rtl/factor_pkg.sv
// Shared types and sizing helpers for the divisibility-scan controller.
package factor_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_MAX_DIV = 17;
  localparam int MASK_W      = DEF_MAX_DIV - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int div_cnt_w(input int max_div);
    return $clog2(max_div + 1);
  endfunction

endpackage

// File: rtl/factor_scan_ctrl_mod_serial.sv
// Restoring serial remainder unit: one load cycle, then WIDTH shift-subtract steps MSB first.
// done is registered and pulses for one cycle after the last step; load always wins.
module mod_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             active;
  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] sub;

  // trial is the WIDTH+1 bit partial remainder; the extra sub bit is the borrow
  always_comb begin
    trial = {part, shreg[WIDTH-1]};
    sub   = {1'b0, trial} - {2'b00, divisor};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      part   <= '0;
      shreg  <= '0;
      cnt    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else if (load) begin
      part   <= '0;
      shreg  <= dividend;
      cnt    <= '0;
      active <= 1'b1;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (active) begin
        part  <= sub[WIDTH+1] ? trial[WIDTH-1:0] : sub[WIDTH-1:0];
        shreg <= {shreg[WIDTH-2:0], 1'b0};
        cnt   <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign rem = part;

endmodule

// File: rtl/factor_scan_ctrl.sv
// Time-shared divisibility scanner: tests divisors 2..MAX_DIV on one serial remainder unit.
// Response registered MAX_DIV-1 * (WIDTH+1) edges after accept; held in DONE until rsp_ready.
module factor_scan_ctrl
  import factor_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MAX_DIV = DEF_MAX_DIV
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_number,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_DIV-2:0] rsp_factors,
  output logic [WIDTH-1:0]   rsp_number,
  input  logic               abort,
  output logic               busy
);

  localparam int D  = MAX_DIV - 1;
  localparam int DW = div_cnt_w(MAX_DIV);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] num;
  logic [D-1:0]     mask, mask_nxt;
  logic [DW-1:0]    d;
  logic             load, accept, step, finish;
  logic [WIDTH-1:0] rem;
  logic             scan_done;

  mod_serial #(.WIDTH(WIDTH)) u_rem (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .dividend (accept ? req_number : num),
    .divisor  (WIDTH'(d)),
    .rem      (rem),
    .done     (scan_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !abort;
        if (req_valid && !abort) begin
          accept    = 1'b1;
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        // abort outranks completion of the final divisor
        if (abort) begin
          state_nxt = IDLE;
        end else if (scan_done) begin
          if (d == DW'(MAX_DIV)) begin
            finish    = 1'b1;
            state_nxt = DONE;
          end else begin
            step = 1'b1;
            load = 1'b1;
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (abort || rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mask_nxt = mask;
    for (int i = 0; i < D; i++) begin
      if (i == int'(d) - 2) mask_nxt[i] = (rem == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num         <= '0;
      mask        <= '0;
      d           <= DW'(2);
      rsp_factors <= '0;
      rsp_number  <= '0;
    end else begin
      if (accept) begin
        num  <= req_number;
        mask <= '0;
        d    <= DW'(2);
      end
      if (step || finish) mask <= mask_nxt;
      if (step) d <= d + 1'b1;
      if (finish) begin
        rsp_factors <= mask_nxt;
        rsp_number  <= num;
      end
    end
  end

endmodule

// File: tb/tb_factor_scan_ctrl.sv
// Scoreboard bench for factor_scan_ctrl: directed requests, decoupled response monitor.
module tb_factor_scan_ctrl;
  import factor_pkg::*;

  localparam int LAT = 144;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [7:0]        req_number = 8'h00;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [MASK_W-1:0] rsp_factors;
  logic [7:0]        rsp_number;
  logic              abort = 1'b0;
  logic              busy;

  typedef struct {
    logic [7:0]        n;
    logic [MASK_W-1:0] f;
    int                acc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   prev_v = 1'b0;
  int   acc;

  factor_scan_ctrl #(.WIDTH(8), .MAX_DIV(17)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_number  (req_number),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_factors (rsp_factors),
    .rsp_number  (rsp_number),
    .abort       (abort),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Response monitor: pops the scoreboard on every completed handshake
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (busy) chk("req_ready_while_busy", 32'(req_ready), 32'd0);
      if (rsp_valid && !prev_v && q.size() > 0)
        chk("rsp_latency", 32'(cyc - q[0].acc), 32'(LAT));
      prev_v = rsp_valid;
      if (rsp_valid && rsp_ready && !abort) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp actual number=%0d factors=0x%0h required=no response",
                   rsp_number, rsp_factors);
        end else begin
          mon_e = q.pop_front();
          chk("rsp_number", 32'(rsp_number), 32'(mon_e.n));
          chk("rsp_factors", 32'(rsp_factors), 32'(mon_e.f));
        end
      end
    end
  end

  task automatic send(input logic [7:0] n, input logic [MASK_W-1:0] f, input bit push,
                      output int acc_o);
    bit ok;
    exp_t e;
    ok = 1'b0;
    acc_o = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_number = n;
    for (int k = 0; k < 400; k++) begin
      #1;
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      acc_o = cyc + 1;
      if (push) begin
        e.n = n;
        e.f = f;
        e.acc = acc_o;
        q.push_back(e);
      end
    end
    @(negedge clk);
    req_valid  = 1'b0;
    req_number = 8'hA5;
    #1;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 400 && q.size() != 0; k++) @(negedge clk);
    #3;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rsp_valid_seen", 32'(ok), 32'd1);
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog actual=timeout required=completion");
    finish_run();
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_factors", 32'(rsp_factors), 32'd0);
    chk("reset_rsp_number", 32'(rsp_number), 32'd0);

    // Basic scan with the consumer always ready
    rsp_ready = 1'b1;
    send(8'd12, 16'h0417, 1'b1, acc);
    wait_empty();

    // Back-to-back special and boundary values
    send(8'd0,   16'hFFFF, 1'b1, acc);
    send(8'd1,   16'h0000, 1'b1, acc);
    send(8'd17,  16'h8000, 1'b1, acc);
    send(8'd255, 16'hA00A, 1'b1, acc);
    wait_empty();

    // Backpressure: result held, next request refused until IDLE
    rsp_ready = 1'b0;
    send(8'd12, 16'h0417, 1'b1, acc);
    wait_valid();
    req_valid  = 1'b1;
    req_number = 8'd17;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_factors", 32'(rsp_factors), 32'h0417);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    send(8'd17, 16'h8000, 1'b1, acc);
    wait_empty();

    // Abort mid-scan drops the request entirely
    send(8'd12, 16'h0417, 1'b0, acc);
    while (cyc < acc + 49) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    repeat (150) @(negedge clk);
    send(8'd255, 16'hA00A, 1'b1, acc);
    wait_empty();

    // Abort coinciding with the response handshake
    rsp_ready = 1'b0;
    send(8'd12, 16'h0417, 1'b0, acc);
    wait_valid();
    abort = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_hs_busy", 32'(busy), 32'd0);
    chk("abort_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    abort = 1'b0;
    repeat (10) @(negedge clk);

    // Asynchronous reset in the middle of a scan
    send(8'd12, 16'h0417, 1'b0, acc);
    while (cyc < acc + 69) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_factors", 32'(rsp_factors), 32'd0);
    chk("arst_rsp_number", 32'(rsp_number), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    repeat (200) @(negedge clk);
    send(8'd1, 16'h0000, 1'b1, acc);
    wait_empty();

    finish_run();
  end

endmodule
